dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set data width in bits; legal range >= 1.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of register stages; legal range >= 1.
REQ-003 Parameter RESET_VAL, default 0, WIDTH bits, SHALL set the value loaded into every data stage on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous and active-high; sampled on the rising edge of clk.
REQ-006 en  input  1  SHALL advance the pipeline by one stage when high.
REQ-007 flush  input  1  SHALL invalidate all stages when high.
REQ-008 d  input  WIDTH  SHALL carry data into stage 0.
REQ-009 d_valid  input  1  SHALL tag d as valid.
REQ-010 q  output  WIDTH  SHALL present the data in stage DEPTH-1.
REQ-011 q_valid  output  1  SHALL present the valid bit of stage DEPTH-1.
REQ-012 taps  output  WIDTH*DEPTH  SHALL expose stage k data at bits [k*WIDTH +: WIDTH].
REQ-013 count  output  $clog2(DEPTH+1)  SHALL report the number of valid stages.
REQ-014 full / empty  output  1 each  SHALL equal (count==DEPTH) and (count==0).

Function
REQ-015 Priority per edge SHALL be reset > flush > en > hold.
REQ-016 With en=1 and no flush: stage0 <= d, valid0 <= d_valid, and stage i <= stage i-1, valid i <= valid i-1 for i=1..DEPTH-1.
REQ-017 With en=0 and no flush/reset: all data, valids and count SHALL hold.
REQ-018 Latency SHALL be exactly DEPTH en-qualified edges from d sampling to q; cycles with en=0 do not count.
REQ-019 flush=1 SHALL clear all valid bits and set count to 0 on that edge; data registers hold; d is not captured even if en=1.
REQ-020 On an en edge, count SHALL become count + d_valid - valid[DEPTH-1], computed without overflow or underflow, so it always equals the population of valid bits.
REQ-021 Simultaneous entry and exit (d_valid=1, q_valid=1, en=1) SHALL leave count unchanged.
REQ-022 DEPTH=1 SHALL behave as a single enabled register: q equals the d captured on the previous en edge.
REQ-023 Invalid data SHALL still shift; q carries whatever data occupies the last stage regardless of q_valid.
REQ-024 All outputs SHALL be driven directly from registers or from count compares, with no combinational path from any input to any output.

Reset
REQ-025 On reset: every stage data = RESET_VAL, every valid = 0, count = 0, so q = RESET_VAL, q_valid = 0, empty = 1, full = 0.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight data on that edge, regardless of en or flush.
REQ-027 Before the first reset edge, no output value SHALL be guaranteed.

Structure
REQ-028 Shared package dff_pkg SHALL hold the default WIDTH/DEPTH constants and a function computing the count width.
REQ-029 One sub-module, dff_stage, SHALL hold one WIDTH-bit data register plus its valid bit with reset/flush/en inputs, instantiated DEPTH times via generate.
REQ-030 count SHALL be a dedicated register updated per REQ-020 and SHALL NOT be recomputed by a popcount.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-031 Reset held 2 cycles -> q=0x00, q_valid=0, count=0, empty=1, taps=0.
REQ-032 en=1, d_valid=1, d=0x11,0x22,0x33,0x44 on 4 edges -> after edge 4: q=0x11, q_valid=1, count=4, full=1, taps=0x11223344 (stage3..stage0).
REQ-033 Continue en=1 with d=0x55, d_valid=1 -> q=0x22, count stays 4; then d_valid=0 for 4 edges -> count decrements 4,3,2,1,0 as q_valid drains.
REQ-034 Load 0xA1 then en=0 for 5 cycles, then en=1 -> q=0xA1 only after the 4th en edge; state frozen while en=0.
REQ-035 Pipeline holding 3 valid entries, flush=1 with en=1 and d=0xFF, d_valid=1 -> count=0, q_valid=0, 0xFF not captured.
REQ-036 Reset pulsed for 1 cycle while full with en=1 -> next cycle q=0x00, q_valid=0, count=0; an additional run with DEPTH=1 confirms one-edge latency.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared constants for the enabled, flushable data pipeline.
// Holds default geometry and the count-width helper.
package dff_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to hold 0..depth valid entries.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Ports: clk, reset, flush, en, d/d_valid in, q/q_valid out.
module dff_stage
  import dff_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Flush drops only the valid bit; data is left in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage enabled data pipeline with valid tags, flush and a
// running occupancy count. Ports: clk, reset, en, flush, d, d_valid,
// q, q_valid, taps (all stage data), count, full, empty.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         d,
  input  logic                     d_valid,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [WIDTH*DEPTH-1:0]   taps,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] sd  [DEPTH];
  logic             sv  [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  logic             vin [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign din[k] = d;
      assign vin[k] = d_valid;
    end else begin : g_body
      assign din[k] = sd[k-1];
      assign vin[k] = sv[k-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .en      (en),
      .d       (din[k]),
      .d_valid (vin[k]),
      .q       (sd[k]),
      .q_valid (sv[k])
    );

    assign taps[k*WIDTH +: WIDTH] = sd[k];
  end

  logic [CW-1:0] count_r;
  logic          last_v;

  assign last_v = sv[DEPTH-1];

  // Occupancy tracks entry minus exit; both or neither leaves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else if (en) begin
      if (d_valid && !last_v) begin
        count_r <= count_r + CW'(1);
      end else if (!d_valid && last_v) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  assign q       = sd[DEPTH-1];
  assign q_valid = last_v;
  assign count   = count_r;
  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == '0);

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed vector table, DEPTH=1 sequence and
// random stimulus against a shift-array reference model.
module tb_dff_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  d = '0;
  logic        d_valid = 1'b0;

  logic [7:0]  q;
  logic        q_valid;
  logic [31:0] taps;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  logic [7:0]  q1;
  logic        q1_valid;
  logic [7:0]  taps1;
  logic [0:0]  count1;
  logic        full1;
  logic        empty1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .flush   (flush),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .taps    (taps),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .flush   (flush),
    .d       (d),
    .d_valid (d_valid),
    .q       (q1),
    .q_valid (q1_valid),
    .taps    (taps1),
    .count   (count1),
    .full    (full1),
    .empty   (empty1)
  );

  // Reference model: stage 0 is newest, stage 3 feeds q.
  logic [7:0] md [4];
  logic       mv [4];
  logic [7:0] m1d;
  logic       m1v;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e,
                            input logic f, input logic [7:0] dd,
                            input logic dv);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        md[i] = 8'h00;
        mv[i] = 1'b0;
      end
      m1d = 8'h00;
      m1v = 1'b0;
    end else if (f) begin
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      m1v = 1'b0;
    end else if (e) begin
      for (int i = 3; i > 0; i--) begin
        md[i] = md[i-1];
        mv[i] = mv[i-1];
      end
      md[0] = dd;
      mv[0] = dv;
      m1d = dd;
      m1v = dv;
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic f,
                       input logic [7:0] dd, input logic dv);
    reset   = r;
    en      = e;
    flush   = f;
    d       = dd;
    d_valid = dv;
    @(posedge clk);
    model_step(r, e, f, dd, dv);
    #1;
  endtask

  task automatic check_model(input int step);
    int          pop;
    logic [31:0] et;
    pop = 0;
    for (int i = 0; i < 4; i++) begin
      pop += int'(mv[i]);
      et[i*8 +: 8] = md[i];
    end
    chk($sformatf("rnd%0d.q", step), 64'(q), 64'(md[3]));
    chk($sformatf("rnd%0d.qv", step), 64'(q_valid), 64'(mv[3]));
    chk($sformatf("rnd%0d.taps", step), 64'(taps), 64'(et));
    chk($sformatf("rnd%0d.cnt", step), 64'(count), 64'(pop));
    chk($sformatf("rnd%0d.full", step), 64'(full), 64'(pop == 4));
    chk($sformatf("rnd%0d.empty", step), 64'(empty), 64'(pop == 0));
    chk($sformatf("rnd%0d.q1", step), 64'(q1), 64'(m1d));
    chk($sformatf("rnd%0d.q1v", step), 64'(q1_valid), 64'(m1v));
    chk($sformatf("rnd%0d.cnt1", step), 64'(count1), 64'(m1v));
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        fl;
    logic [7:0]  d;
    logic        dv;
    logic [7:0]  q;
    logic        qv;
    int          cnt;
    logic [31:0] taps;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(
    input logic r, input logic e, input logic f, input logic [7:0] dd,
    input logic dv, input logic [7:0] eq, input logic eqv,
    input int ec, input logic [31:0] et);
    vec_t v;
    v.rst = r; v.en = e; v.fl = f; v.d = dd; v.dv = dv;
    v.q = eq; v.qv = eqv; v.cnt = ec; v.taps = et;
    return v;
  endfunction

  initial begin
    // reset held two cycles
    vt.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 32'h00000000));
    vt.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 32'h00000000));
    // fill 11..44
    vt.push_back(mk(0, 1, 0, 8'h11, 1, 8'h00, 0, 1, 32'h00000011));
    vt.push_back(mk(0, 1, 0, 8'h22, 1, 8'h00, 0, 2, 32'h00001122));
    vt.push_back(mk(0, 1, 0, 8'h33, 1, 8'h00, 0, 3, 32'h00112233));
    vt.push_back(mk(0, 1, 0, 8'h44, 1, 8'h11, 1, 4, 32'h11223344));
    // entry and exit together, then drain
    vt.push_back(mk(0, 1, 0, 8'h55, 1, 8'h22, 1, 4, 32'h22334455));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'h33, 1, 3, 32'h33445500));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'h44, 1, 2, 32'h44550000));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'h55, 1, 1, 32'h55000000));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 32'h00000000));
    // A1 with en stalls: latency counts en edges only
    vt.push_back(mk(0, 1, 0, 8'hA1, 1, 8'h00, 0, 1, 32'h000000A1));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h00, 0, 1, 32'h000000A1));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 32'h0000A100));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 32'h00A10000));
    vt.push_back(mk(0, 1, 0, 8'h00, 0, 8'hA1, 1, 1, 32'hA1000000));
    // three valid entries, then flush with en and d=FF
    vt.push_back(mk(0, 1, 0, 8'hB1, 1, 8'h00, 0, 1, 32'h000000B1));
    vt.push_back(mk(0, 1, 0, 8'hB2, 1, 8'h00, 0, 2, 32'h0000B1B2));
    vt.push_back(mk(0, 1, 0, 8'hB3, 1, 8'h00, 0, 3, 32'h00B1B2B3));
    vt.push_back(mk(0, 1, 1, 8'hFF, 1, 8'h00, 0, 0, 32'h00B1B2B3));
    vt.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 32'h00B1B2B3));
    // fill while invalid data drains, then reset mid-stream
    vt.push_back(mk(0, 1, 0, 8'hC1, 1, 8'hB1, 0, 1, 32'hB1B2B3C1));
    vt.push_back(mk(0, 1, 0, 8'hC2, 1, 8'hB2, 0, 2, 32'hB2B3C1C2));
    vt.push_back(mk(0, 1, 0, 8'hC3, 1, 8'hB3, 0, 3, 32'hB3C1C2C3));
    vt.push_back(mk(0, 1, 0, 8'hC4, 1, 8'hC1, 1, 4, 32'hC1C2C3C4));
    vt.push_back(mk(1, 1, 0, 8'hD5, 1, 8'h00, 0, 0, 32'h00000000));
    // invalid data still shifts
    vt.push_back(mk(0, 1, 0, 8'hE1, 0, 8'h00, 0, 0, 32'h000000E1));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].en, vt[i].fl, vt[i].d, vt[i].dv);
      chk($sformatf("vec%0d.q", i), 64'(q), 64'(vt[i].q));
      chk($sformatf("vec%0d.qv", i), 64'(q_valid), 64'(vt[i].qv));
      chk($sformatf("vec%0d.cnt", i), 64'(count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d.taps", i), 64'(taps), 64'(vt[i].taps));
      chk($sformatf("vec%0d.full", i), 64'(full), 64'(vt[i].cnt == 4));
      chk($sformatf("vec%0d.empty", i), 64'(empty), 64'(vt[i].cnt == 0));
    end

    // DEPTH=1: one-edge latency, hold, flush
    apply(1, 0, 0, 8'h00, 0);
    chk("d1.rst.q", 64'(q1), 64'h00);
    chk("d1.rst.empty", 64'(empty1), 64'h1);
    apply(0, 1, 0, 8'h5A, 1);
    chk("d1.cap.q", 64'(q1), 64'h5A);
    chk("d1.cap.qv", 64'(q1_valid), 64'h1);
    chk("d1.cap.full", 64'(full1), 64'h1);
    chk("d1.cap.taps", 64'(taps1), 64'h5A);
    apply(0, 0, 0, 8'h77, 0);
    chk("d1.hold.q", 64'(q1), 64'h5A);
    chk("d1.hold.cnt", 64'(count1), 64'h1);
    apply(0, 1, 0, 8'h3C, 0);
    chk("d1.inv.q", 64'(q1), 64'h3C);
    chk("d1.inv.empty", 64'(empty1), 64'h1);
    apply(0, 1, 0, 8'h66, 1);
    apply(0, 1, 1, 8'h99, 1);
    chk("d1.fl.q", 64'(q1), 64'h66);
    chk("d1.fl.qv", 64'(q1_valid), 64'h0);
    chk("d1.fl.cnt", 64'(count1), 64'h0);

    // Random stimulus against the model
    for (int s = 0; s < 3000; s++) begin
      apply($urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            8'($urandom),
            1'($urandom));
      check_model(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
